// File: rtl/tick_recovery_pkg.sv
// Shared definitions for the divided-clock recovery path.
// Holds the lock-tracking state encoding and the default half-period,
// which the clock divider also uses so that both ends agree.
package tick_recovery_pkg;

    // Half-period of the divided clock, in main-clock cycles.
    localparam int DEFAULT_N = 250000;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_t;

endpackage : tick_recovery_pkg

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a history flop. It produces registered,
// single-cycle pulses for the rising and falling edges of an asynchronous
// level input. The button inputs use it as well.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   i_async  in   level signal from another clock domain
//   o_rise   out  one-cycle pulse per synchronised rising edge
//   o_fall   out  one-cycle pulse per synchronised falling edge
module sync_edge_detect
    import tick_recovery_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_rise;
    logic r_fall;
    logic w_rise;
    logic w_fall;

    // r_s3 holds the previous synchronised level, so these are true for
    // exactly one cycle per transition of r_s2.
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // NOTE: sequential state uses non-blocking assignments so each flop
    // samples the value its neighbour held before this edge; with blocking
    // assignments the synchroniser would collapse into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : sync_edge_detect

// File: rtl/tick_recovery.sv
// Consumer end of the divided-clock path. Brings the slow toggling clock into
// the main clock domain as tick/tock enable strobes, measures the spacing
// between successive edges, and tracks whether that spacing matches the
// expected half-period. Early, late and missing edges are reported while
// locked.
//
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous, active-high reset
//   i_slow_in        in   divided clock, asynchronous to clk
//   o_tick           out  one-cycle pulse per rising edge of i_slow_in
//   o_tock           out  one-cycle pulse per falling edge of i_slow_in
//   o_locked         out  high while edge spacing stays within N +/- TOL
//   o_err_early      out  pulse: interval below N-TOL while locked
//   o_err_late       out  pulse: interval above N+TOL while locked
//   o_err_missing    out  pulse: no edge within N+TOL cycles while locked
//   o_last_interval  out  most recent edge-to-edge interval in clk cycles
module tick_recovery
    import tick_recovery_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int TOL        = 4,
    parameter int LOCK_COUNT = 4,
    parameter int W          = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_slow_in,
    output logic         o_tick,
    output logic         o_tock,
    output logic         o_locked,
    output logic         o_err_early,
    output logic         o_err_late,
    output logic         o_err_missing,
    output logic [W-1:0] o_last_interval
);

    // Tolerance window; the lower bound is clamped so it cannot wrap.
    localparam logic [W-1:0] WIN_LO  = (N > TOL) ? W'(N - TOL) : '0;
    localparam logic [W-1:0] WIN_HI  = W'(N + TOL);
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam int           GW      = $clog2(LOCK_COUNT + 1);

    logic          w_rise;
    logic          w_fall;
    logic          w_edge;
    logic [W-1:0]  w_interval;
    logic          w_good;
    logic          w_short;

    state_t        r_state;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_last_interval;
    logic [GW-1:0] r_good_cnt;
    logic          r_have_ref;
    logic          r_err_early;
    logic          r_err_late;
    logic          r_err_missing;

    state_t        w_state_nxt;
    logic [GW-1:0] w_good_cnt_nxt;
    logic          w_have_ref_nxt;
    logic          w_early_nxt;
    logic          w_late_nxt;
    logic          w_missing_nxt;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_slow_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    // The edge cycle itself is part of the interval, hence cnt+1. A
    // saturated counter reports all-ones rather than wrapping to zero.
    assign w_interval = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + W'(1);
    assign w_good     = (w_interval >= WIN_LO) && (w_interval <= WIN_HI);
    assign w_short    = (w_interval < WIN_LO);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_have_ref_nxt = r_have_ref;
        w_early_nxt    = 1'b0;
        w_late_nxt     = 1'b0;
        w_missing_nxt  = 1'b0;

        if (w_edge) begin
            if (!r_have_ref) begin
                // The counter has been running since reset, not since an
                // edge, so the first interval is meaningless.
                w_have_ref_nxt = 1'b1;
            end else begin
                case (r_state)
                    ACQ: begin
                        if (!w_good) begin
                            w_good_cnt_nxt = '0;
                        end else if (r_good_cnt == GW'(LOCK_COUNT - 1)) begin
                            w_state_nxt    = LOCKED;
                            w_good_cnt_nxt = '0;
                        end else begin
                            w_good_cnt_nxt = r_good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (!w_good) begin
                            w_early_nxt = w_short;
                            w_late_nxt  = ~w_short;
                            w_state_nxt = LOST;
                        end
                    end
                    LOST: begin
                        if (w_good) begin
                            w_state_nxt    = ACQ;
                            w_good_cnt_nxt = GW'(1);
                        end
                    end
                    default: begin
                        w_state_nxt    = ACQ;
                        w_good_cnt_nxt = '0;
                    end
                endcase
            end
        end else if ((r_state == LOCKED) && (r_cnt == WIN_HI)) begin
            // The next edge could only be late now; report it as missing
            // straight away instead of waiting for it.
            w_missing_nxt = 1'b1;
            w_state_nxt   = LOST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ACQ;
            r_cnt           <= '0;
            r_last_interval <= '0;
            r_good_cnt      <= '0;
            r_have_ref      <= 1'b0;
            r_err_early     <= 1'b0;
            r_err_late      <= 1'b0;
            r_err_missing   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_good_cnt    <= w_good_cnt_nxt;
            r_have_ref    <= w_have_ref_nxt;
            r_err_early   <= w_early_nxt;
            r_err_late    <= w_late_nxt;
            r_err_missing <= w_missing_nxt;

            if (w_edge) begin
                r_cnt           <= '0;
                r_last_interval <= w_interval;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_tick          = w_rise;
    assign o_tock          = w_fall;
    assign o_locked        = (r_state == LOCKED);
    assign o_err_early     = r_err_early;
    assign o_err_late      = r_err_late;
    assign o_err_missing   = r_err_missing;
    assign o_last_interval = r_last_interval;

endmodule : tick_recovery

// File: tb/tb_tick_recovery.sv
module tb_tick_recovery;

    localparam int N   = 10;
    localparam int TOL = 1;
    localparam int LC  = 3;
    localparam int W   = 32;
    localparam int W4  = 4;
    localparam int HI  = N + TOL;
    localparam int LO  = N - TOL;
    localparam longint CAP4 = (64'd1 << W4) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          slow_in = 1'b0;

    logic          tick, tock, locked, err_early, err_late, err_missing;
    logic [W-1:0]  last_interval;
    logic          tick4, tock4, locked4, err_early4, err_late4, err_missing4;
    logic [W4-1:0] last_interval4;

    tick_recovery #(.N(N), .TOL(TOL), .LOCK_COUNT(LC), .W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_slow_in       (slow_in),
        .o_tick          (tick),
        .o_tock          (tock),
        .o_locked        (locked),
        .o_err_early     (err_early),
        .o_err_late      (err_late),
        .o_err_missing   (err_missing),
        .o_last_interval (last_interval)
    );

    // Narrow-counter instance: same stimulus, used to see saturation.
    tick_recovery #(.N(N), .TOL(TOL), .LOCK_COUNT(LC), .W(W4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .i_slow_in       (slow_in),
        .o_tick          (tick4),
        .o_tock          (tock4),
        .o_locked        (locked4),
        .o_err_early     (err_early4),
        .o_err_late      (err_late4),
        .o_err_missing   (err_missing4),
        .o_last_interval (last_interval4)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model (works in whole half-periods) -------
    typedef enum int {EV_MISSING = 0, EV_EARLY = 1, EV_LATE = 2,
                      EV_LOCK = 3, EV_TICK = 4, EV_TOCK = 5} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned cyc;
        bit          locked;
        bit          li_chk;
        longint      li;
    } ev_t;
    typedef enum int {M_ACQ, M_LOCKED, M_LOST} mode_t;

    ev_t         exp_q[$];
    mode_t       m_mode;
    bit          m_have_ref;
    int          m_good;
    int unsigned m_prev_toggle;
    longint      m_li;
    bit          m_li_ok;

    task automatic push(input ev_kind_t k, input int unsigned c, input bit lk);
        ev_t e;
        e.kind = k; e.cyc = c; e.locked = lk; e.li_chk = m_li_ok; e.li = m_li;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_mode = M_ACQ; m_have_ref = 1'b0; m_good = 0;
        m_li = 0; m_li_ok = 1'b1; m_prev_toggle = 0;
    endtask

    // A toggle applied on the negedge of cycle t is seen as a strobe in
    // cycle t+3; flags raised by that edge appear in cycle t+4.
    task automatic model_edge(input int unsigned t, input bit rising);
        int unsigned tick_c;
        int unsigned g;
        bit good;
        tick_c = t + 3;
        if (!m_have_ref) begin
            push(rising ? EV_TICK : EV_TOCK, tick_c, 1'b0);
            m_have_ref = 1'b1;
            m_li_ok = 1'b0;
        end else begin
            g = t - m_prev_toggle;
            good = (g >= LO) && (g <= HI);
            if (m_mode == M_LOCKED && g > HI + 1) begin
                push(EV_MISSING, m_prev_toggle + 3 + HI + 2, 1'b0);
                m_mode = M_LOST;
            end
            push(rising ? EV_TICK : EV_TOCK, tick_c, m_mode == M_LOCKED);
            m_li = g; m_li_ok = 1'b1;
            case (m_mode)
                M_ACQ: begin
                    if (good) begin
                        m_good++;
                        if (m_good == LC) begin
                            m_mode = M_LOCKED;
                            push(EV_LOCK, tick_c + 1, 1'b1);
                        end
                    end else m_good = 0;
                end
                M_LOCKED: begin
                    if (!good) begin
                        push(g < LO ? EV_EARLY : EV_LATE, tick_c + 1, 1'b0);
                        m_mode = M_LOST;
                    end
                end
                default: begin
                    if (good) begin m_mode = M_ACQ; m_good = 1; end
                end
            endcase
        end
        m_prev_toggle = t;
    endtask

    task automatic model_stall();
        if (m_mode == M_LOCKED) begin
            push(EV_MISSING, m_prev_toggle + 3 + HI + 2, 1'b0);
            m_mode = M_LOST;
        end
    endtask

    // Called on a negedge; toggles slow_in g cycles later.
    task automatic half(input int g);
        model_edge(cyc + g, !slow_in);
        repeat (g) @(negedge clk);
        slow_in = !slow_in;
    endtask

    function automatic longint cap4(input longint v);
        return (v > CAP4) ? CAP4 : v;
    endfunction

    // ---------------- monitor ---------------------------------------------
    logic [5:0] fired;
    bit         prev_locked = 1'b0;
    ev_t        got;

    always @(negedge clk) begin
        if (rst) begin
            prev_locked = 1'b0;
        end else begin
            fired = {tock, tick, locked & ~prev_locked, err_late, err_early, err_missing};
            for (int k = 0; k < 6; k++) begin
                if (fired[k]) begin
                    check("event_was_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        got = exp_q.pop_front();
                        check("event_kind", k, int'(got.kind));
                        check("event_cycle", cyc, got.cyc);
                        check("locked", locked, got.locked);
                        check("locked_w4", locked4, got.locked);
                        if (got.li_chk) begin
                            check("last_interval", last_interval, got.li);
                            check("last_interval_w4", last_interval4, cap4(got.li));
                        end
                    end
                end
            end
            prev_locked = locked;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_tock"}, tock, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err_early"}, err_early, 0);
        check({tag, "_err_late"}, err_late, 0);
        check({tag, "_err_missing"}, err_missing, 0);
        check({tag, "_last_interval"}, last_interval, 0);
        check({tag, "_last_interval_w4"}, last_interval4, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        int g;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) half(N);     // lock after 4th edge
        half(12);                                // late
        for (int i = 0; i < 4; i++) half(N);     // LOST -> ACQ -> LOCKED
        half(8);                                 // early
        for (int i = 0; i < 4; i++) half(N);
        half(9); half(11); half(10); half(9); half(11); half(9);   // tolerance edges
        half(13);                                // missing coincides with the edge
        for (int i = 0; i < 4; i++) half(N);

        for (int i = 0; i < 60; i++) begin
            g = ($urandom_range(0, 9) < 7) ? int'($urandom_range(LO - 1, HI + 1))
                                           : int'($urandom_range(3, 20));
            half(g);
        end

        for (int i = 0; i < 6; i++) half(N);
        model_stall();
        repeat (40) @(negedge clk);              // stalled: one missing, nothing more
        for (int i = 0; i < 6; i++) half(N);     // first gap saturates the W=4 counter

        repeat (6) @(negedge clk);
        check("locked_before_reset", locked, m_mode == M_LOCKED);
        check("drained_before_reset", exp_q.size(), 0);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        slow_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) half(N);     // reference edge then relock
        model_stall();
        repeat (HI + 15) @(negedge clk);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("pending_at_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tick_recovery
